// File: rtl/div_if.sv
// Handshake bundle between the EX-stage issue logic and the iterative divider.
interface div_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         flush;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] result;
  logic         div_by_zero;

  modport master (
    output start, op, dividend, divisor, flush, out_ready,
    input  in_ready, out_valid, result, div_by_zero
  );

  modport slave (
    input  start, op, dividend, divisor, flush, out_ready,
    output in_ready, out_valid, result, div_by_zero
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with sign fix-up and valid/ready handshake.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for start; special cases and cache hits resolve here
// CALC  | N shift/trial-subtract iterations on operand magnitudes
// FIX   | sign correction, result registered
// DONE  | out_valid high until out_ready
module div_unit #(
  parameter int N = 32
) (
  input  logic  clock,
  input  logic  reset,
  div_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic          op_rem;
  logic          q_neg;
  logic          r_neg;
  logic [N-1:0]  rem;
  logic [N-1:0]  quo;
  logic [N-1:0]  dvsr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  result_q;
  logic          dbz_q;

  logic          accept;
  logic          is_signed;
  logic          dvd_neg;
  logic          dvs_neg;
  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
  logic          div_zero;
  logic          ovf;
  logic          hit;
  logic [N:0]    rem_sh;
  logic [N:0]    diff;
  logic          borrow;
  logic [N-1:0]  rem_nx;
  logic [N-1:0]  quo_nx;
  logic [N-1:0]  quo_fix;
  logic [N-1:0]  rem_fix;

  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign is_signed = ~bus.op[0];
  assign dvd_neg   = is_signed & bus.dividend[N-1];
  assign dvs_neg   = is_signed & bus.divisor[N-1];
  assign dvd_mag   = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_mag   = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
  assign div_zero  = (bus.divisor == '0);
  assign ovf       = is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == ALL_ONES);

  // The shifted partial remainder needs N+1 bits: the bit leaving rem must take part in the compare.
  assign rem_sh = {rem, quo[N-1]};
  assign diff   = rem_sh - {1'b0, dvsr};
  assign borrow = diff[N];
  assign rem_nx = borrow ? rem_sh[N-1:0] : diff[N-1:0];
  assign quo_nx = {quo[N-2:0], ~borrow};

  assign quo_fix = q_neg ? (~quo + 1'b1) : quo;
  assign rem_fix = r_neg ? (~rem + 1'b1) : rem;

`ifdef DIV_RESULT_CACHE_EN
  logic         c_valid;
  logic [N-1:0] c_dvd;
  logic [N-1:0] c_dvs;
  logic         c_sgn;
  logic [N-1:0] c_quo;
  logic [N-1:0] c_rem;
  logic [N-1:0] raw_dvd;
  logic [N-1:0] raw_dvs;
  logic         raw_sgn;

  assign hit = c_valid && (bus.dividend == c_dvd) && (bus.divisor == c_dvs)
               && (is_signed == c_sgn);

  // Only normally computed results reach FIX, so specials never enter the cache.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      c_valid <= 1'b0;
      c_dvd   <= '0;
      c_dvs   <= '0;
      c_sgn   <= 1'b0;
      c_quo   <= '0;
      c_rem   <= '0;
      raw_dvd <= '0;
      raw_dvs <= '0;
      raw_sgn <= 1'b0;
    end else begin
      if (accept) begin
        raw_dvd <= bus.dividend;
        raw_dvs <= bus.divisor;
        raw_sgn <= is_signed;
      end
      if (state == FIX && !bus.flush) begin
        c_valid <= 1'b1;
        c_dvd   <= raw_dvd;
        c_dvs   <= raw_dvs;
        c_sgn   <= raw_sgn;
        c_quo   <= quo_fix;
        c_rem   <= rem_fix;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) state_nx = (div_zero || ovf || hit) ? DONE : CALC;
        CALC: if (cnt == '0) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: if (bus.out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      op_rem <= bus.op[1];
      q_neg  <= dvd_neg ^ dvs_neg;
      r_neg  <= dvd_neg;
      rem    <= '0;
      quo    <= dvd_mag;
      dvsr   <= dvs_mag;
      cnt    <= CW'(N-1);
      if (div_zero) begin
        result_q <= bus.op[1] ? bus.dividend : ALL_ONES;
        dbz_q    <= 1'b1;
      end else if (ovf) begin
        result_q <= bus.op[1] ? '0 : MIN_NEG;
        dbz_q    <= 1'b0;
      end else if (hit) begin
`ifdef DIV_RESULT_CACHE_EN
        result_q <= bus.op[1] ? c_rem : c_quo;
`endif
        dbz_q    <= 1'b0;
      end
    end else if (state == CALC && !bus.flush) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt - 1'b1;
    end else if (state == FIX && !bus.flush) begin
      result_q <= op_rem ? rem_fix : quo_fix;
      dbz_q    <= 1'b0;
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: arithmetic reference model, randomized and directed operations.
module tb_div_unit;
  localparam int N = 32;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  // Latency counted in edges from the accept edge inclusive: accept, N iterations, fix.
  localparam int LAT_FULL = N + 2;
  localparam int LAT_FAST = 1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  div_if #(.N(N)) bus ();

  div_unit #(.N(N)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] res;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int accept_cycle = 0;
  int rises = 0;
  int ready_mode = 0;

  logic         mc_valid = 1'b0;
  logic [N-1:0] mc_a;
  logic [N-1:0] mc_b;
  logic         mc_sgn;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, plus a record of the last cacheable operation.
  task automatic model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       output exp_t e);
    longint sa, sbv, q, r;
    logic sgn;
    bit is_hit;
    sgn = !op[0];
    e.dbz = 1'b0;
    if (b == '0) begin
      e.res = op[1] ? a : '1;
      e.dbz = 1'b1;
      e.lat = LAT_FAST;
    end else begin
      if (sgn) begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
      end else begin
        sa  = longint'(a);
        sbv = longint'(b);
      end
      q = sa / sbv;
      r = sa % sbv;
      e.res = op[1] ? r[N-1:0] : q[N-1:0];
      if (sgn && a == MIN_NEG && b == '1) begin
        e.lat = LAT_FAST;
      end else begin
        is_hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        is_hit = mc_valid && mc_a == a && mc_b == b && mc_sgn == sgn;
`endif
        e.lat = is_hit ? LAT_FAST : LAT_FULL;
        mc_valid = 1'b1;
        mc_a = a;
        mc_b = b;
        mc_sgn = sgn;
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit push);
    int t;
    exp_t e;
    t = 0;
    @(negedge clock);
    while (!bus.in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", bus.in_ready, 1);
      return;
    end
    bus.start = 1'b1;
    bus.op = op;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    accept_cycle = cyc - 1;
    if (push) begin
      model(op, a, b, e);
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("valid_timeout", bus.out_valid, 1);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: latency on out_valid rise, stability while stalled, value on handshake.
  initial begin
    bit prev_valid;
    bit hold_prev;
    logic [N-1:0] held_res;
    logic held_dbz;
    exp_t e;
    prev_valid = 0;
    hold_prev = 0;
    held_res = '0;
    held_dbz = 1'b0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        prev_valid = 0;
        hold_prev = 0;
      end else begin
        if (bus.out_valid && hold_prev) begin
          chk("hold_result", bus.result, held_res);
          chk("hold_dbz", bus.div_by_zero, held_dbz);
        end
        if (bus.out_valid && !prev_valid) begin
          rises++;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got out_valid=1, expected no pending result (cycle %0d)", cyc);
          end else begin
            chk("latency", cyc - accept_cycle, sb[0].lat);
          end
        end
        if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("div_by_zero", bus.div_by_zero, e.dbz);
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        held_res = bus.result;
        held_dbz = bus.div_by_zero;
        prev_valid = bus.out_valid;
      end
    end
  end

  initial begin
    int t;
    int r0;
    logic [1:0] op;
    logic [N-1:0] a, b;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_dbz", bus.div_by_zero, 0);

    // Stall the consumer for 5 cycles on the first result.
    ready_mode = 2;
    issue(2'b01, 100, 7, 1);
    wait_valid();
    repeat (5) @(negedge clock);
    ready_mode = 0;
    issue(2'b11, 100, 7, 1);
    issue(2'b00, -7, 2, 1);
    issue(2'b10, -7, 2, 1);
    issue(2'b00, 7, -2, 1);
    issue(2'b10, 7, -2, 1);
    issue(2'b00, 5, 0, 1);
    issue(2'b11, 5, 0, 1);
    issue(2'b00, MIN_NEG, '1, 1);
    issue(2'b10, MIN_NEG, '1, 1);

    // Asynchronous reset in the middle of an iteration.
    issue(2'b01, 100, 7, 0);
    repeat (10) @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_result", bus.result, 0);
    mc_valid = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;

    // Flush with a colliding start while iterating.
    issue(2'b01, 100, 7, 0);
    repeat (4) @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.dividend = 50;
    bus.divisor = 5;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_out_valid", bus.out_valid, 0);
    r0 = rises;
    repeat (40) @(negedge clock);
    chk("flush_no_valid", rises, r0);
    issue(2'b00, 9, 3, 1);

    // Quotient/remainder pair, then the same operands unsigned.
    issue(2'b00, 1000, 33, 1);
    issue(2'b10, 1000, 33, 1);
    issue(2'b01, 1000, 33, 1);

    ready_mode = 1;
    a = 0;
    b = 1;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = '0; end
        1: begin a = MIN_NEG; b = '1; end
        2: ;
        3, 4, 5: begin
          a = N'($urandom_range(0, 300));
          b = N'($urandom_range(1, 40));
          if ($urandom_range(0, 1) == 1) a = ~a + 1'b1;
          if ($urandom_range(0, 1) == 1) b = ~b + 1'b1;
        end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      issue(op, a, b, 1);
    end

    ready_mode = 0;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    chk("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
